quick_spi_sequencer: RTL and testbench



---
 rtl/quick_spi_sequencer.sv | 162 ++++++++++++++++
 tb/tb_quick_spi_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quick_spi_sequencer.sv
// Command sequencer in front of quick_spi: queues commands, issues them one at a time,
// captures read data into a response FIFO and halts when a transaction never completes.
module quick_spi_sequencer #(
    parameter int NUMBER_OF_SLAVES    = 2,
    parameter int SLAVE_INDEX_WIDTH   = 1,
    parameter int INCOMING_DATA_WIDTH = 8,
    parameter int OUTGOING_DATA_WIDTH = 16,
    parameter int CMD_FIFO_DEPTH      = 4,
    parameter int RSP_FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES      = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [SLAVE_INDEX_WIDTH-1:0]   cmd_slave_index,
    input  logic                           cmd_operation,
    input  logic [OUTGOING_DATA_WIDTH-1:0] cmd_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [INCOMING_DATA_WIDTH-1:0] rsp_data,
    output logic [SLAVE_INDEX_WIDTH-1:0]   rsp_slave_index,
    output logic                           busy,
    output logic                           timeout_error,
    input  logic                           error_clear,
    output logic                           spi_enable,
    output logic                           spi_start_transaction,
    output logic [NUMBER_OF_SLAVES-1:0]    spi_slave,
    output logic                           spi_operation,
    output logic [OUTGOING_DATA_WIDTH-1:0] spi_outgoing_data,
    input  logic                           spi_end_of_transaction,
    input  logic [INCOMING_DATA_WIDTH-1:0] spi_incoming_data
);

    localparam int CMD_AW = $clog2(CMD_FIFO_DEPTH);
    localparam int CMD_PW = CMD_AW + 1;
    localparam int RSP_AW = $clog2(RSP_FIFO_DEPTH);
    localparam int RSP_PW = RSP_AW + 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_EOT, HALT} state_t;

    state_t state, state_next;

    logic [CMD_PW-1:0]              cmd_wr_ptr, cmd_rd_ptr, cmd_wr_ptr_next, cmd_rd_ptr_next;
    logic [SLAVE_INDEX_WIDTH-1:0]   cmd_slave_mem [CMD_FIFO_DEPTH];
    logic                           cmd_op_mem    [CMD_FIFO_DEPTH];
    logic [OUTGOING_DATA_WIDTH-1:0] cmd_data_mem  [CMD_FIFO_DEPTH];
    logic                           cmd_full, cmd_empty, cmd_push, cmd_pop;

    logic [RSP_PW-1:0]              rsp_wr_ptr, rsp_rd_ptr;
    logic [SLAVE_INDEX_WIDTH-1:0]   rsp_slave_mem [RSP_FIFO_DEPTH];
    logic [INCOMING_DATA_WIDTH-1:0] rsp_data_mem  [RSP_FIFO_DEPTH];
    logic                           rsp_full, rsp_empty, rsp_push, rsp_pop;

    logic [TO_W-1:0]                wdog;
    logic                           timeout_hit, error_cleared;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign cmd_empty = (cmd_wr_ptr == cmd_rd_ptr);
    assign cmd_full  = (cmd_wr_ptr[CMD_AW] != cmd_rd_ptr[CMD_AW]) &&
                       (cmd_wr_ptr[CMD_AW-1:0] == cmd_rd_ptr[CMD_AW-1:0]);
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;

    assign rsp_empty       = (rsp_wr_ptr == rsp_rd_ptr);
    assign rsp_full        = (rsp_wr_ptr[RSP_AW] != rsp_rd_ptr[RSP_AW]) &&
                             (rsp_wr_ptr[RSP_AW-1:0] == rsp_rd_ptr[RSP_AW-1:0]);
    assign rsp_valid       = !rsp_empty;
    assign rsp_pop         = rsp_valid && rsp_ready;
    assign rsp_data        = rsp_empty ? '0 : rsp_data_mem[rsp_rd_ptr[RSP_AW-1:0]];
    assign rsp_slave_index = rsp_empty ? '0 : rsp_slave_mem[rsp_rd_ptr[RSP_AW-1:0]];

    always_comb begin
        state_next    = state;
        cmd_pop       = 1'b0;
        rsp_push      = 1'b0;
        timeout_hit   = 1'b0;
        error_cleared = 1'b0;
        case (state)
            IDLE: begin
                // A READ may only issue when its response is guaranteed a slot.
                if (!cmd_empty && (cmd_op_mem[cmd_rd_ptr[CMD_AW-1:0]] || !rsp_full)) begin
                    cmd_pop    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT_EOT;
            WAIT_EOT: begin
                if (spi_end_of_transaction) begin
                    rsp_push   = !spi_operation;
                    state_next = IDLE;
                end else if (wdog == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = HALT;
                end
            end
            HALT: begin
                if (error_clear) begin
                    error_cleared = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_wr_ptr_next = cmd_push ? cmd_wr_ptr + CMD_PW'(1) : cmd_wr_ptr;
    assign cmd_rd_ptr_next = cmd_pop  ? cmd_rd_ptr + CMD_PW'(1) : cmd_rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            cmd_wr_ptr            <= '0;
            cmd_rd_ptr            <= '0;
            rsp_wr_ptr            <= '0;
            rsp_rd_ptr            <= '0;
            wdog                  <= '0;
            busy                  <= 1'b0;
            timeout_error         <= 1'b0;
            spi_enable            <= 1'b0;
            spi_start_transaction <= 1'b0;
            spi_slave             <= '0;
            spi_operation         <= 1'b0;
            spi_outgoing_data     <= '0;
        end else begin
            state      <= state_next;
            cmd_wr_ptr <= cmd_wr_ptr_next;
            cmd_rd_ptr <= cmd_rd_ptr_next;
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RSP_PW'(1);
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RSP_PW'(1);

            if (cmd_push) begin
                cmd_slave_mem[cmd_wr_ptr[CMD_AW-1:0]] <= cmd_slave_index;
                cmd_op_mem[cmd_wr_ptr[CMD_AW-1:0]]    <= cmd_operation;
                cmd_data_mem[cmd_wr_ptr[CMD_AW-1:0]]  <= cmd_data;
            end
            if (rsp_push) begin
                rsp_slave_mem[rsp_wr_ptr[RSP_AW-1:0]] <= spi_slave[SLAVE_INDEX_WIDTH-1:0];
                rsp_data_mem[rsp_wr_ptr[RSP_AW-1:0]]  <= spi_incoming_data;
            end
            if (cmd_pop) begin
                spi_slave         <= NUMBER_OF_SLAVES'(cmd_slave_mem[cmd_rd_ptr[CMD_AW-1:0]]);
                spi_operation     <= cmd_op_mem[cmd_rd_ptr[CMD_AW-1:0]];
                spi_outgoing_data <= cmd_data_mem[cmd_rd_ptr[CMD_AW-1:0]];
            end

            if (state == ISSUE)         wdog <= '0;
            else if (state == WAIT_EOT) wdog <= wdog + TO_W'(1);

            if (timeout_hit)        timeout_error <= 1'b1;
            else if (error_cleared) timeout_error <= 1'b0;

            // Registered outputs are computed from next-cycle state so they line up with it.
            spi_start_transaction <= (state_next == ISSUE);
            spi_enable            <= (state_next != HALT);
            busy                  <= (cmd_wr_ptr_next != cmd_rd_ptr_next) ||
                                     (state_next == ISSUE) || (state_next == WAIT_EOT);
        end
    end

endmodule

// File: tb/tb_quick_spi_sequencer.sv
// Directed self-checking bench for quick_spi_sequencer; the SPI side is driven by hand.
module tb_quick_spi_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [0:0]  cmd_slave_index = '0;
    logic        cmd_operation = 1'b0;
    logic [15:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic [0:0]  rsp_slave_index;
    logic        busy;
    logic        timeout_error;
    logic        error_clear = 1'b0;
    logic        spi_enable;
    logic        spi_start_transaction;
    logic [1:0]  spi_slave;
    logic        spi_operation;
    logic [15:0] spi_outgoing_data;
    logic        spi_end_of_transaction = 1'b0;
    logic [7:0]  spi_incoming_data = '0;

    int checks = 0;
    int passes = 0;

    quick_spi_sequencer #(
        .NUMBER_OF_SLAVES(2),
        .SLAVE_INDEX_WIDTH(1),
        .INCOMING_DATA_WIDTH(8),
        .OUTGOING_DATA_WIDTH(16),
        .CMD_FIFO_DEPTH(4),
        .RSP_FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slave_index(cmd_slave_index),
        .cmd_operation(cmd_operation), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_slave_index(rsp_slave_index), .busy(busy), .timeout_error(timeout_error),
        .error_clear(error_clear), .spi_enable(spi_enable),
        .spi_start_transaction(spi_start_transaction), .spi_slave(spi_slave),
        .spi_operation(spi_operation), .spi_outgoing_data(spi_outgoing_data),
        .spi_end_of_transaction(spi_end_of_transaction), .spi_incoming_data(spi_incoming_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic s, input logic op, input logic [15:0] d);
        cmd_slave_index = s;
        cmd_operation   = op;
        cmd_data        = d;
        cmd_valid       = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for a start pulse, then ends the transaction one cycle later.
    task automatic run_txn(input logic [7:0] rdata, output int lat, output logic [15:0] dseen);
        lat   = -1;
        dseen = '0;
        for (int i = 0; i < 40; i++) begin
            if (spi_start_transaction === 1'b1) begin
                lat = i;
                break;
            end
            tick();
        end
        if (lat < 0) return;
        dseen = spi_outgoing_data;
        tick();
        spi_end_of_transaction = 1'b1;
        spi_incoming_data      = rdata;
        tick();
        spi_end_of_transaction = 1'b0;
        spi_incoming_data      = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if ({cmd_ready, rsp_valid, busy, timeout_error, spi_enable, spi_start_transaction, spi_operation} !== 7'b1000000)
            $display("FAIL reset_flags got=%b exp=%b", {cmd_ready, rsp_valid, busy, timeout_error, spi_enable, spi_start_transaction, spi_operation}, 7'b1000000); else passes++;
        checks++; if ({rsp_data, rsp_slave_index, spi_slave, spi_outgoing_data} !== 27'h0)
            $display("FAIL reset_data got=%h exp=0", {rsp_data, rsp_slave_index, spi_slave, spi_outgoing_data}); else passes++;
        reset = 1'b0;
        tick();
        checks++; if (spi_enable !== 1'b1) $display("FAIL reset_enable_after got=%b exp=1", spi_enable); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy_after got=%b exp=0", busy); else passes++;
    endtask

    task automatic test_single_write();
        push_cmd(1'b1, 1'b1, 16'hA55A);
        checks++; if (spi_start_transaction !== 1'b0) $display("FAIL wr_start_c1 got=%b exp=0", spi_start_transaction); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL wr_busy_c1 got=%b exp=1", busy); else passes++;
        tick();
        checks++; if (spi_start_transaction !== 1'b1) $display("FAIL wr_start_c2 got=%b exp=1", spi_start_transaction); else passes++;
        checks++; if ({spi_slave, spi_operation, spi_outgoing_data} !== {2'b01, 1'b1, 16'hA55A})
            $display("FAIL wr_cmd got=%h exp=%h", {spi_slave, spi_operation, spi_outgoing_data}, {2'b01, 1'b1, 16'hA55A}); else passes++;
        tick();
        checks++; if (spi_start_transaction !== 1'b0) $display("FAIL wr_start_pulse got=%b exp=0", spi_start_transaction); else passes++;
        tick();
        tick();
        checks++; if ({spi_slave, spi_outgoing_data} !== {2'b01, 16'hA55A})
            $display("FAIL wr_hold got=%h exp=%h", {spi_slave, spi_outgoing_data}, {2'b01, 16'hA55A}); else passes++;
        spi_end_of_transaction = 1'b1;
        spi_incoming_data      = 8'hEE;
        tick();
        spi_end_of_transaction = 1'b0;
        spi_incoming_data      = '0;
        checks++; if (busy !== 1'b0) $display("FAIL wr_busy_done got=%b exp=0", busy); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL wr_no_rsp got=%b exp=0", rsp_valid); else passes++;
    endtask

    task automatic test_single_read();
        int lat;
        logic [15:0] d;
        push_cmd(1'b0, 1'b0, 16'h0000);
        run_txn(8'h3C, lat, d);
        checks++; if (lat !== 1) $display("FAIL rd_latency got=%0d exp=1", lat); else passes++;
        checks++; if ({rsp_valid, rsp_data, rsp_slave_index} !== {1'b1, 8'h3C, 1'b0})
            $display("FAIL rd_rsp got=%h exp=%h", {rsp_valid, rsp_data, rsp_slave_index}, {1'b1, 8'h3C, 1'b0}); else passes++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rd_pop got=%b exp=0", rsp_valid); else passes++;
    endtask

    task automatic test_cmd_backpressure();
        int lat;
        logic [15:0] d;
        push_cmd(1'b0, 1'b1, 16'h1111);
        tick();
        checks++; if (spi_start_transaction !== 1'b1) $display("FAIL bp_blocker_start got=%b exp=1", spi_start_transaction); else passes++;
        cmd_operation = 1'b1;
        cmd_valid     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_data = 16'h2000 + 16'(i);
            checks++; if (cmd_ready !== 1'b1) $display("FAIL bp_ready_%0d got=%b exp=1", i, cmd_ready); else passes++;
            tick();
        end
        checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_full got=%b exp=0", cmd_ready); else passes++;
        cmd_data = 16'h2004;
        tick();
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_full_hold got=%b exp=0", cmd_ready); else passes++;
        spi_end_of_transaction = 1'b1;
        tick();
        spi_end_of_transaction = 1'b0;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_ready_on_pop got=%b exp=0", cmd_ready); else passes++;
        tick();
        checks++; if ({cmd_ready, spi_start_transaction, spi_outgoing_data} !== {2'b11, 16'h2000})
            $display("FAIL bp_first_issue got=%h exp=%h", {cmd_ready, spi_start_transaction, spi_outgoing_data}, {2'b11, 16'h2000}); else passes++;
        tick();
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_fifth_stored got=%b exp=0", cmd_ready); else passes++;
        spi_end_of_transaction = 1'b1;
        tick();
        spi_end_of_transaction = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            run_txn(8'hEE, lat, d);
            checks++; if (lat !== 1 || d !== 16'h2000 + 16'(k))
                $display("FAIL bp_drain_%0d got=lat%0d/%h exp=lat1/%h", k, lat, d, 16'h2000 + 16'(k)); else passes++;
        end
        checks++; if ({busy, rsp_valid} !== 2'b00) $display("FAIL bp_idle got=%b exp=00", {busy, rsp_valid}); else passes++;
    endtask

    task automatic test_rsp_backpressure();
        int lat;
        logic [15:0] d;
        logic seen;
        for (int k = 0; k < 4; k++) begin
            push_cmd(1'(k), 1'b0, 16'h0000);
            run_txn(8'h40 + 8'(k), lat, d);
            checks++; if (lat !== 1) $display("FAIL rbp_lat_%0d got=%0d exp=1", k, lat); else passes++;
        end
        checks++; if ({rsp_valid, rsp_data, rsp_slave_index} !== {1'b1, 8'h40, 1'b0})
            $display("FAIL rbp_head got=%h exp=%h", {rsp_valid, rsp_data, rsp_slave_index}, {1'b1, 8'h40, 1'b0}); else passes++;
        push_cmd(1'b1, 1'b0, 16'h0000);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | spi_start_transaction;
            tick();
        end
        checks++; if (seen !== 1'b0) $display("FAIL rbp_stall got=%b exp=0", seen); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL rbp_busy got=%b exp=1", busy); else passes++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        run_txn(8'h44, lat, d);
        checks++; if (lat !== 1) $display("FAIL rbp_release_lat got=%0d exp=1", lat); else passes++;
        for (int k = 1; k <= 4; k++) begin
            checks++; if ({rsp_valid, rsp_data, rsp_slave_index} !== {1'b1, 8'h40 + 8'(k), (k == 4) ? 1'b1 : 1'(k)})
                $display("FAIL rbp_rsp_%0d got=%h exp=%h", k, {rsp_valid, rsp_data, rsp_slave_index},
                         {1'b1, 8'h40 + 8'(k), (k == 4) ? 1'b1 : 1'(k)}); else passes++;
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        checks++; if (rsp_valid !== 1'b0) $display("FAIL rbp_empty got=%b exp=0", rsp_valid); else passes++;
    endtask

    task automatic test_ordering();
        int lat;
        logic [15:0] d;
        logic [15:0] od [4];
        logic        oo [4];
        logic        os [4];
        logic [7:0]  rd [4];
        od = '{16'h0001, 16'h00AA, 16'h0002, 16'h00BB};
        oo = '{1'b1, 1'b0, 1'b1, 1'b0};
        os = '{1'b0, 1'b1, 1'b1, 1'b0};
        rd = '{8'hEE, 8'h11, 8'hEE, 8'h22};
        push_cmd(1'b0, 1'b1, 16'h0BAD);
        tick();
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_slave_index = os[i];
            cmd_operation   = oo[i];
            cmd_data        = od[i];
            tick();
        end
        cmd_valid = 1'b0;
        spi_end_of_transaction = 1'b1;
        tick();
        spi_end_of_transaction = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_txn(rd[i], lat, d);
            checks++; if (lat !== 1 || d !== od[i])
                $display("FAIL ord_issue_%0d got=lat%0d/%h exp=lat1/%h", i, lat, d, od[i]); else passes++;
        end
        checks++; if ({rsp_valid, rsp_data, rsp_slave_index} !== {1'b1, 8'h11, 1'b1})
            $display("FAIL ord_rsp0 got=%h exp=%h", {rsp_valid, rsp_data, rsp_slave_index}, {1'b1, 8'h11, 1'b1}); else passes++;
        rsp_ready = 1'b1;
        tick();
        checks++; if ({rsp_valid, rsp_data, rsp_slave_index} !== {1'b1, 8'h22, 1'b0})
            $display("FAIL ord_rsp1 got=%h exp=%h", {rsp_valid, rsp_data, rsp_slave_index}, {1'b1, 8'h22, 1'b0}); else passes++;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL ord_rsp_count got=%b exp=0", rsp_valid); else passes++;
    endtask

    task automatic test_watchdog();
        int lat;
        logic [15:0] d;
        logic seen;
        push_cmd(1'b0, 1'b1, 16'h5555);
        push_cmd(1'b1, 1'b0, 16'h0077);
        push_cmd(1'b0, 1'b1, 16'h0066);
        for (int i = 0; i < 15; i++) tick();
        checks++; if ({timeout_error, spi_enable} !== 2'b01) $display("FAIL wd_early got=%b exp=01", {timeout_error, spi_enable}); else passes++;
        tick();
        checks++; if ({timeout_error, spi_enable} !== 2'b10) $display("FAIL wd_fire got=%b exp=10", {timeout_error, spi_enable}); else passes++;
        checks++; if ({rsp_valid, busy, cmd_ready} !== 3'b011) $display("FAIL wd_queue got=%b exp=011", {rsp_valid, busy, cmd_ready}); else passes++;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | spi_start_transaction | spi_enable | ~timeout_error;
        end
        checks++; if (seen !== 1'b0) $display("FAIL wd_halt_hold got=%b exp=0", seen); else passes++;
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        checks++; if ({timeout_error, spi_enable, spi_start_transaction} !== 3'b010)
            $display("FAIL wd_clear got=%b exp=010", {timeout_error, spi_enable, spi_start_transaction}); else passes++;
        tick();
        checks++; if ({spi_start_transaction, spi_slave, spi_operation, spi_outgoing_data} !== {1'b1, 2'b01, 1'b0, 16'h0077})
            $display("FAIL wd_resume got=%h exp=%h", {spi_start_transaction, spi_slave, spi_operation, spi_outgoing_data},
                     {1'b1, 2'b01, 1'b0, 16'h0077}); else passes++;
        for (int i = 0; i < 16; i++) tick();
        spi_end_of_transaction = 1'b1;
        spi_incoming_data      = 8'h5A;
        tick();
        spi_end_of_transaction = 1'b0;
        spi_incoming_data      = '0;
        checks++; if ({timeout_error, spi_enable} !== 2'b01) $display("FAIL wd_eot_wins got=%b exp=01", {timeout_error, spi_enable}); else passes++;
        checks++; if ({rsp_valid, rsp_data, rsp_slave_index} !== {1'b1, 8'h5A, 1'b1})
            $display("FAIL wd_eot_rsp got=%h exp=%h", {rsp_valid, rsp_data, rsp_slave_index}, {1'b1, 8'h5A, 1'b1}); else passes++;
        rsp_ready = 1'b1;
        run_txn(8'hEE, lat, d);
        rsp_ready = 1'b0;
        checks++; if (lat !== 1 || d !== 16'h0066) $display("FAIL wd_last got=lat%0d/%h exp=lat1/0066", lat, d); else passes++;
        checks++; if ({busy, rsp_valid} !== 2'b00) $display("FAIL wd_idle got=%b exp=00", {busy, rsp_valid}); else passes++;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [15:0] d;
        logic seen;
        push_cmd(1'b1, 1'b0, 16'h0000);
        run_txn(8'h99, lat, d);
        checks++; if (rsp_valid !== 1'b1) $display("FAIL rst_pre_rsp got=%b exp=1", rsp_valid); else passes++;
        push_cmd(1'b1, 1'b1, 16'hC001);
        push_cmd(1'b0, 1'b1, 16'hC002);
        push_cmd(1'b1, 1'b1, 16'hC003);
        reset = 1'b1;
        tick();
        checks++; if ({cmd_ready, rsp_valid, busy, timeout_error, spi_enable, spi_start_transaction, spi_operation} !== 7'b1000000)
            $display("FAIL rst_mid_flags got=%b exp=%b", {cmd_ready, rsp_valid, busy, timeout_error, spi_enable, spi_start_transaction, spi_operation}, 7'b1000000); else passes++;
        checks++; if ({rsp_data, rsp_slave_index, spi_slave, spi_outgoing_data} !== 27'h0)
            $display("FAIL rst_mid_data got=%h exp=0", {rsp_data, rsp_slave_index, spi_slave, spi_outgoing_data}); else passes++;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | spi_start_transaction | busy | rsp_valid;
        end
        checks++; if (seen !== 1'b0) $display("FAIL rst_mid_quiet got=%b exp=0", seen); else passes++;
        checks++; if (spi_enable !== 1'b1) $display("FAIL rst_mid_enable got=%b exp=1", spi_enable); else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=expired exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_cmd_backpressure();
        test_rsp_backpressure();
        test_ordering();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
